// File: rtl/fetch_stage_pkg.sv
// Shared processor package for the instruction fetch stage.
// Holds the fetch FSM state encoding, the instruction size in bytes and the
// default first fetch address after reset.
package fetch_stage_pkg;

  // Fetch FSM states:
  //   ST_REQ  - presenting a request to instruction memory
  //   ST_WAIT - one request accepted, waiting for its response word
  //   ST_HOLD - a valid instruction is held for the decode stage
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Every instruction is one 32-bit word.
  localparam logic [63:0] INSTR_BYTES = 64'd4;

  // First fetch address after reset when the top-level parameter is not overridden.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // Force an address onto a word boundary.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// Signals:
//   imem_req_valid  fetch request to instruction memory (fetch -> mem)
//   imem_req_ready  memory accepts the request this cycle (mem -> fetch)
//   imem_addr       64-bit word-aligned fetch byte address (fetch -> mem)
//   imem_rsp_valid  instruction word returned this cycle (mem -> fetch)
//   imem_rsp_data   returned 32-bit instruction word (mem -> fetch)
// Modports: master = fetch stage side, slave = memory side.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Fetch-to-decode pipeline register (if_id_reg).
// Holds one instruction and its address for the decode/immediate-generation
// stage. load captures a new word and raises valid, clear drops valid, and
// otherwise the contents hold so decode sees a stable instruction.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   load                capture instr_in/pc_in and set valid
//   clear               drop valid (consumed or flushed)
//   instr_in, pc_in     word and address to capture
//   valid, instr, pc    registered outputs toward decode
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [63:0] pc_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [63:0] pc
);

  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [63:0] pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= 32'h0;
      pc_reg    <= 64'h0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
    end else if (clear) begin
      // Data is left in place; only the valid flag matters once cleared.
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues one word fetch at a time to instruction memory, hands the returned
// word to decode through if_id_reg, and follows taken branch/jump redirects.
// A redirect that arrives while a request is outstanding marks that response
// for discard (drop flag) so the stale word never reaches decode.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   imem              instruction memory bus (master side)
//   redirect_valid    taken branch/jump: flush and refetch at redirect_pc
//   redirect_pc       new fetch address, bits [1:0] ignored
//   id_ready          decode accepts the held instruction
//   id_valid          id_instr/id_pc hold a valid instruction
//   id_instr, id_pc   instruction and its address for decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  input  logic                 id_ready,
  output logic                 id_valid,
  output logic [31:0]          id_instr,
  output logic [63:0]          id_pc
);

  fetch_state_e state_reg;
  logic [63:0]  pc_reg;
  logic         drop_reg;
  logic         req_valid_reg;

  logic [63:0]  redirect_target;
  logic [63:0]  pc_plus4;
  logic         rsp_good;
  logic         id_load;
  logic         id_clear;

  assign redirect_target = word_align(redirect_pc);
  // Plain 64-bit add: wraps from the last word of the address space to 0.
  assign pc_plus4        = pc_reg + INSTR_BYTES;

  // A response is only delivered when no redirect has invalidated it,
  // either earlier (drop_reg) or in this same cycle.
  assign rsp_good = (state_reg == ST_WAIT) && imem.imem_rsp_valid
                    && !drop_reg && !redirect_valid;
  assign id_load  = rsp_good;
  assign id_clear = (state_reg == ST_HOLD) && (redirect_valid || id_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_REQ;
      pc_reg        <= word_align(RESET_PC);
      drop_reg      <= 1'b0;
      req_valid_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem.imem_req_ready) begin
            // Handshake done; a same-cycle redirect makes the accepted
            // request stale, so its response will be dropped.
            state_reg     <= ST_WAIT;
            req_valid_reg <= 1'b0;
            drop_reg      <= redirect_valid;
            if (redirect_valid) begin
              pc_reg <= redirect_target;
            end
          end else if (redirect_valid) begin
            // Nothing accepted yet, so simply retarget the pending request.
            pc_reg <= redirect_target;
          end
        end

        ST_WAIT: begin
          if (imem.imem_rsp_valid) begin
            drop_reg <= 1'b0;
            if (drop_reg || redirect_valid) begin
              state_reg     <= ST_REQ;
              req_valid_reg <= 1'b1;
              if (redirect_valid) begin
                pc_reg <= redirect_target;
              end
            end else begin
              state_reg     <= ST_HOLD;
              req_valid_reg <= 1'b0;
              pc_reg        <= pc_plus4;
            end
          end else if (redirect_valid) begin
            pc_reg   <= redirect_target;
            drop_reg <= 1'b1;
          end
        end

        ST_HOLD: begin
          // Redirect wins over id_ready; both release the held word.
          if (redirect_valid) begin
            pc_reg        <= redirect_target;
            state_reg     <= ST_REQ;
            req_valid_reg <= 1'b1;
          end else if (id_ready) begin
            state_reg     <= ST_REQ;
            req_valid_reg <= 1'b1;
          end
        end

        default: begin
          state_reg     <= ST_REQ;
          req_valid_reg <= 1'b1;
          drop_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_reg;
  assign imem.imem_addr      = pc_reg;

  // pc_reg still holds the address of the word being returned in ST_WAIT.
  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (id_load),
    .clear    (id_clear),
    .instr_in (imem.imem_rsp_data),
    .pc_in    (pc_reg),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a scoreboard of expected
// instructions delivered to decode.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } txn_t;

  txn_t sb[$];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(64'h1000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check request-side outputs.
  task automatic check_req(input string tag, input logic vld, input logic [63:0] addr);
    check({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'(vld));
    if (vld) check({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  // Pop the scoreboard when decode sees a valid instruction.
  task automatic expect_id(input string tag);
    txn_t t;
    check({tag, "_id_valid"}, 64'(id_valid), 64'd1);
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      t = sb.pop_front();
      check({tag, "_id_pc"}, id_pc, t.pc);
      check({tag, "_id_instr"}, 64'(id_instr), 64'(t.instr));
      $display("txn %s: pc=%h instr=%h", tag, id_pc, id_instr);
    end
  endtask

  task automatic give_rsp(input logic [31:0] data, input logic good, input logic [63:0] pc);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    if (good) sb.push_back('{pc: pc, instr: data});
    cyc();
    bus.imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 64'h0;
    id_ready           = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    cyc();
    cyc();
    // Reset state
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_instr", 64'(id_instr), 64'd0);
    check("rst_id_pc", id_pc, 64'd0);
    check_req("rst", 1'b1, 64'h1000);
    rst_n = 1'b1;
    cyc();
    check_req("first", 1'b1, 64'h1000);

    // Basic fetch at RESET_PC
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    check_req("wait1", 1'b0, 64'h0);
    give_rsp(32'h00A00093, 1'b1, 64'h1000);
    expect_id("fetch1");
    // Hold with id_ready low for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("hold_id_valid", 64'(id_valid), 64'd1);
      check("hold_id_pc", id_pc, 64'h1000);
      check("hold_id_instr", 64'(id_instr), 64'h00A00093);
    end
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    check("consumed_id_valid", 64'(id_valid), 64'd0);
    check_req("next", 1'b1, 64'h1004);

    // Ready low 3 cycles: address stays put
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_req("stall", 1'b1, 64'h1004);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;

    // Redirect in WAIT, then stale response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    cyc();
    redirect_valid = 1'b0;
    check_req("redir_wait", 1'b0, 64'h0);
    give_rsp(32'hDEADBEEF, 1'b0, 64'h0);
    check("drop_id_valid", 64'(id_valid), 64'd0);
    check_req("after_drop", 1'b1, 64'h2000);

    // Fetch at target, then flush with redirect + id_ready together
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    give_rsp(32'h11111111, 1'b1, 64'h2000);
    expect_id("fetch2");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    id_ready       = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check_req("flush", 1'b1, 64'h3000);

    // Redirect in REQ without ready, to the top word of memory
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    check_req("top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    give_rsp(32'h00000013, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_id("fetch_top");
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    check_req("wrap", 1'b1, 64'h0);

    // Response outside WAIT ignored
    give_rsp(32'h00000BAD, 1'b0, 64'h0);
    check("stray_id_valid", 64'(id_valid), 64'd0);
    check_req("stray", 1'b1, 64'h0);

    // Redirect in REQ together with ready: response dropped
    redirect_valid     = 1'b1;
    redirect_pc        = 64'h4000;
    bus.imem_req_ready = 1'b1;
    cyc();
    redirect_valid     = 1'b0;
    bus.imem_req_ready = 1'b0;
    check_req("redir_hs", 1'b0, 64'h0);
    give_rsp(32'h55555555, 1'b0, 64'h0);
    check("redir_hs_id_valid", 64'(id_valid), 64'd0);
    check_req("redir_hs_next", 1'b1, 64'h4000);

    // Reset during WAIT; late response ignored
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_req("rst_wait", 1'b1, 64'h1000);
    give_rsp(32'h00000077, 1'b0, 64'h0);
    check("late_id_valid", 64'(id_valid), 64'd0);
    check_req("late", 1'b1, 64'h1000);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 SHALL have port imem_addr  output  64  fetch byte address, bits [1:0] always 0.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump resolved taken, flush and refetch.
REQ-010 SHALL have port redirect_pc  input  64  new fetch address, bits [1:0] ignored.
REQ-011 SHALL have port id_ready  input  1  decode/immediate-generation stage accepts instruction.
REQ-012 SHALL have port id_valid  output  1  id_instr/id_pc hold a valid instruction.
REQ-013 SHALL have port id_instr  output  32  instruction to decode and immediate generator.
REQ-014 SHALL have port id_pc  output  64  address of id_instr.

Function
REQ-015 SHALL implement FSM states REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-016 In REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal the pc register.
REQ-017 In REQ, imem_req_valid high with imem_req_ready high SHALL be the handshake; next state WAIT.
REQ-018 In REQ, imem_addr SHALL stay stable while waiting for ready, except on redirect.
REQ-019 Redirect in REQ without ready: pc <= {redirect_pc[63:2],2'b00}, remain REQ.
REQ-020 Redirect in REQ with ready: pc <= redirect target, drop flag <= 1, go WAIT.
REQ-021 In WAIT without rsp: a redirect loads pc with the target and sets drop.
REQ-022 In WAIT, rsp with drop=1 or same-cycle redirect: discard word, clear drop, go REQ; id_valid stays 0.
REQ-023 In WAIT, good rsp: id_instr <= data, id_pc <= pc, id_valid <= 1, pc <= pc+4 (64-bit wrap), go HOLD.
REQ-024 In HOLD, id_valid SHALL be 1 and id_instr/id_pc SHALL hold stable until consumed or flushed.
REQ-025 In HOLD, redirect SHALL win over id_ready: id_valid <= 0, pc <= target, go REQ.
REQ-026 In HOLD, id_ready without redirect: id_valid <= 0, go REQ next cycle.
REQ-027 A response while not in WAIT SHALL be ignored.
REQ-028 pc+4 from 64'hFFFF_FFFF_FFFF_FFFC SHALL wrap to 0 with no error.

Reset
REQ-029 With rst_n low at a rising edge: state <= REQ, pc <= RESET_PC with bits [1:0] cleared, drop <= 0, id_valid <= 0, id_instr <= 0, id_pc <= 0.
REQ-030 Reset SHALL take priority over all inputs; reset mid-WAIT abandons the outstanding response; first post-reset cycle drives imem_req_valid=1 at RESET_PC.

Structure
REQ-031 FSM state encoding, INSTR_BYTES=4 and default RESET_PC SHALL live in the shared processor package.
REQ-032 The id_valid/id_instr/id_pc register SHALL be one sub-module, if_id_reg (load, clear, hold).

Verification
REQ-033 Reset, RESET_PC=0x1000, ready=1, rsp next cycle with 0x00A00093, id_ready=1 -> id_valid with id_pc=0x1000, next request at 0x1004.
REQ-034 imem_req_ready low 3 cycles -> imem_addr stable at 0x1004 all 3 cycles, imem_req_valid held 1.
REQ-035 Redirect to 0x2002 in WAIT, then rsp 0xDEADBEEF -> word discarded, id_valid stays 0, next request at 0x2000.
REQ-036 HOLD with id_ready=0 for 4 cycles -> id_instr/id_pc unchanged; redirect plus id_ready together -> flushed, refetch at target.
REQ-037 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0x0.
REQ-038 rst_n low during WAIT, rsp arrives the cycle after -> ignored, request at RESET_PC, id_valid=0.
